// File: rtl/rv32_pc_ctrl.sv
// Run-control sequencer for the RV32 PC: boot delay, run/stall/busy decode,
// post-branch squash window, debug halt/step/resume and retired-advance count.
module rv32_pc_ctrl #(
    parameter int unsigned BOOT_CYCLES  = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_halt,
    input  logic        ex_branch,
    input  logic        load_use,
    input  logic        mem_busy,
    input  logic        dbg_halt_req,
    input  logic        dbg_resume_req,
    input  logic        dbg_step_req,
    output logic        pc_enable,
    output logic        pc_busy,
    output logic        pc_stall,
    output logic        pc_normal_op,
    output logic        squash,
    output logic        dbg_halted,
    output logic [31:0] instret
);

    localparam int unsigned BOOT_W  = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned SQ_W    = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BOOT_W-1:0]  boot_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [SQ_W-1:0]    squash_cnt;
    logic               active;
    logic               advance;
    logic               accept;
    logic               boot_last;
    logic               drain_last;

    assign boot_last  = (boot_cnt == BOOT_W'(BOOT_CYCLES - 1));
    assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; boot and drain timers only move on non-busy cycles
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: begin
                if (boot_last && !mem_busy) begin
                    state_nxt = boot_halt ? ST_HALTED : ST_RUN;
                end
            end
            ST_RUN: begin
                if (dbg_halt_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_STEP: begin
                if (advance) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_last && !mem_busy) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (dbg_resume_req) begin
                    state_nxt = ST_RUN;
                end else if (dbg_step_req) begin
                    state_nxt = ST_STEP;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Output decode: mem_busy > ex_branch > load_use
    always_comb begin
        active       = 1'b0;
        advance      = 1'b0;
        accept       = 1'b0;
        pc_enable    = 1'b0;
        pc_busy      = 1'b0;
        pc_stall     = 1'b0;
        pc_normal_op = 1'b0;
        squash       = 1'b0;
        dbg_halted   = 1'b0;

        active       = (state == ST_RUN) || (state == ST_STEP);
        advance      = active && !mem_busy && (ex_branch || !load_use);
        accept       = active && !mem_busy && ex_branch;
        pc_enable    = active;
        pc_busy      = active && mem_busy;
        pc_stall     = active && !mem_busy && load_use && !ex_branch;
        pc_normal_op = active && !ex_branch && !load_use;
        squash       = (squash_cnt != '0);
        dbg_halted   = (state == ST_HALTED);
    end

    // Timers, squash window and retired-advance counter
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_cnt   <= '0;
            drain_cnt  <= '0;
            squash_cnt <= '0;
            instret    <= '0;
        end else begin
            if (state == ST_BOOT && !mem_busy) begin
                boot_cnt <= boot_last ? '0 : boot_cnt + BOOT_W'(1);
            end

            if (state != ST_DRAIN) begin
                drain_cnt <= '0;
            end else if (!mem_busy) begin
                drain_cnt <= drain_last ? '0 : drain_cnt + DRAIN_W'(1);
            end

            // A newer branch restarts the window even while one is open
            if (accept) begin
                squash_cnt <= SQ_W'(FLUSH_CYCLES);
            end else if (squash_cnt != '0 && !mem_busy) begin
                squash_cnt <= squash_cnt - SQ_W'(1);
            end

            if (advance) begin
                instret <= instret + 32'd1;
            end
        end
    end

endmodule

// File: doc/rv32_pc_ctrl.md
# rv32_pc_ctrl

Run-control sequencer for the RV32 program counter. It owns the enable/busy/stall/normal-op controls of the PC register and the pipeline squash window after a taken branch, which together decide when and how the PC advances. It also implements a boot delay and a debug halt/step/resume state machine. It sits between the execute-stage branch resolution, the hazard unit, the data-memory interface and the PC, and counts retired PC advances.

## Interface
- BOOT_CYCLES, default 4: cycles spent in BOOT after reset release (≥1).
- FLUSH_CYCLES, default 2: cycles of squash after an accepted taken branch (≥1).
- DRAIN_CYCLES, default 3: cycles spent in DRAIN before halting (≥1).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  **synchronous, active-high** reset.
- boot_halt  in  1  sampled at BOOT exit: 1 → HALTED, 0 → RUN.
- ex_branch  in  1  taken branch/jump resolved in execute this cycle.
- load_use  in  1  hazard unit requests the PC hold.
- mem_busy  in  1  data memory busy; freezes the PC and all counters.
- dbg_halt_req, dbg_resume_req, dbg_step_req  in  1 each  single-cycle debug requests.
- pc_enable  out  1  to PC `enable`.
- pc_busy  out  1  to PC `busy`.
- pc_stall  out  1  to PC `stall`.
- pc_normal_op  out  1  to PC `normal_op`.
- squash  out  1  kill IF/ID and ID/EX contents.
- dbg_halted  out  1  core is halted.
- instret  out  32  count of PC advances.

## Operation
- States: BOOT, RUN, STEP, DRAIN, HALTED. Reset → BOOT.
- BOOT: boot_cnt counts up to BOOT_CYCLES−1, then moves to RUN or HALTED according to boot_halt. Debug requests are ignored.
- Active = state is RUN or STEP. pc_enable = active.
- pc_busy = active & mem_busy.
- pc_stall = active & ~mem_busy & load_use & ~ex_branch.
- pc_normal_op = active & ~ex_branch & ~load_use.
- Advance = active & ~mem_busy & (ex_branch | ~load_use). Priority is mem_busy > ex_branch > load_use.
- Branch accept = active & ~mem_busy & ex_branch. It loads squash_cnt with FLUSH_CYCLES. It also reloads a nonzero squash_cnt, so a newer branch wins.
- squash_cnt decrements when it is nonzero and ~mem_busy. squash = (squash_cnt ≠ 0). Squash continues in DRAIN and HALTED until the count reaches 0.
- instret increments on each advance and wraps from 0xFFFF_FFFF to 0.
- RUN + dbg_halt_req → DRAIN. If ex_branch is asserted in the same cycle, the branch is accepted first.
- STEP: the first advance moves to DRAIN. While no advance occurs, the block stays in STEP.
- DRAIN: pc_enable=0. drain_cnt counts to DRAIN_CYCLES−1 (frozen while mem_busy), then the state moves to HALTED.
- HALTED: dbg_halted=1.
  - dbg_resume_req → RUN.
  - Otherwise dbg_step_req → STEP.
  - Resume wins over step when both are asserted.
  - dbg_halt_req is ignored.
- dbg_halt_req in STEP, DRAIN or BOOT is ignored. Step/resume requests outside HALTED are ignored.

## Timing
- Reset values:
  - pc_enable, pc_busy, pc_stall, pc_normal_op, squash, dbg_halted = 0.
  - instret = 0.
  - All internal counters = 0.
- rst has priority over all inputs and applies on any cycle, including mid-squash and mid-DRAIN. The cycle after rst deasserts is BOOT cycle 0.
- The first RUN cycle is BOOT_CYCLES cycles after rst deasserts. pc_enable rises in that cycle.
- pc_enable, pc_busy, pc_stall and pc_normal_op are combinational from registered state and current inputs. They have zero-cycle latency to the PC.
- squash rises the cycle after branch accept and stays high for exactly FLUSH_CYCLES non-busy cycles.
- dbg_halted rises DRAIN_CYCLES cycles after DRAIN entry (plus any mem_busy cycles). It falls the cycle after the resume or step request.
- A step yields exactly one instret increment.

## Test plan
- Reset then run, boot_halt=0, BOOT_CYCLES=4 → pc_enable=0 for 4 cycles, then 1. pc_normal_op=1, instret increments by 1 per cycle.
- ex_branch pulse for 1 cycle in RUN → pc_normal_op=0 that cycle, squash=1 for the next 2 cycles. Second ex_branch during squash → squash extends 2 cycles from the second branch.
- mem_busy=1 for 3 cycles with load_use=1 and ex_branch=1 → pc_busy=1, pc_stall=0, instret and squash_cnt frozen. Branch accepted in the first cycle after mem_busy drops.
- dbg_halt_req in RUN → pc_enable=0 next cycle, dbg_halted=1 after 3 cycles. dbg_step_req → exactly one advance (instret+1), then halted again after 3 drain cycles.
- dbg_resume_req and dbg_step_req in the same cycle while HALTED → RUN, continuous advance.
- rst asserted mid-DRAIN with squash active → all outputs 0 next cycle, instret=0, BOOT restarts. instret preloaded near 0xFFFF_FFFF wraps to 0 on the next advance.
